// File: rtl/i2s_dac_tx.sv
// I2S transmitter: divides mclk_in into bclk/lrck and shifts out one stereo
// pair per frame, MSB first with the standard one-BCLK delay after the lrck edge.
module i2s_dac_tx #(
  parameter int MCLK_DIV = 8,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                mclk_in,
  input  logic                rst,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PAD_W   = SLOT_W - SAMPLE_W;
  localparam int HALF    = MCLK_DIV / 2;
  localparam int DIV_W   = $clog2(MCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_next;
  logic                 f_event;
  logic                 frame_wrap;
  logic                 load;
  logic                 accept;
  logic                 full;
  logic                 out_of_reset;
  logic [SAMPLE_W-1:0]  hold_left;
  logic [SAMPLE_W-1:0]  hold_right;
  logic [FRAME_W-1:0]   frame_word;
  logic [FRAME_W-1:0]   shreg;

  // Handshake: a pair is taken on any mclk_in edge where s_valid & s_ready;
  // s_ready only depends on the holding register, never on s_valid.
  assign s_ready = out_of_reset & ~full;
  assign accept  = s_valid & s_ready;

  assign f_event    = (state == RUN) && (div_cnt == DIV_W'(MCLK_DIV - 1));
  assign frame_wrap = f_event && (bit_cnt == BIT_W'(FRAME_W - 1));
  assign frame_word = full ? {hold_left, {PAD_W{1'b0}}, hold_right, {PAD_W{1'b0}}}
                           : '0;

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        div_next = '0;
        bit_next = '0;
        if (enable) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        div_next = f_event ? '0 : div_cnt + 1'b1;
        if (f_event) begin
          bit_next = frame_wrap ? '0 : bit_cnt + 1'b1;
        end
        // enable is only honoured at frame boundaries so frames are never cut short
        if (frame_wrap) begin
          if (enable) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      out_of_reset <= 1'b0;
      full         <= 1'b0;
      hold_left    <= '0;
      hold_right   <= '0;
      shreg        <= '0;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      sdata        <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_next;
      div_cnt      <= div_next;
      bit_cnt      <= bit_next;
      out_of_reset <= 1'b1;
      bclk         <= (state_next == RUN) && (div_next >= DIV_W'(HALF));
      lrck         <= (state_next == RUN) && (bit_next >= BIT_W'(SLOT_W));
      frame_start  <= load;
      underrun     <= load & ~full;

      // The wrap edge always shows the final padding bit, which is zero.
      if (load) begin
        shreg <= frame_word;
        sdata <= 1'b0;
      end else if (frame_wrap) begin
        sdata <= 1'b0;
      end else if (f_event) begin
        sdata <= shreg[FRAME_W-1];
        shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end

      // Accept can only land on an empty register, so it wins over a load.
      if (load) begin
        full <= 1'b0;
      end
      if (accept) begin
        full       <= 1'b1;
        hold_left  <= s_left;
        hold_right <= s_right;
      end
    end
  end

endmodule
